// File: rtl/otter_mdu.sv
// rtl/otter_mdu.sv - Iterative RV32M multiply/divide unit; MDU_FAST_MUL_EN selects single-cycle multiplies
module otter_mdu (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_n;
    logic [4:0]  count;
    logic [2:0]  op;
    logic        neg_q, neg_r;
    logic [63:0] acc, mcand;
    logic [31:0] mplier;    // multiplier for MUL*, dividend/quotient shift register for DIV*
    logic [31:0] rem, divisor;

    logic        a_signed, b_signed, accept;
    logic [31:0] abs_a, abs_b;
    logic        div_zero, div_ovf, special, fast_mul;
    logic [31:0] special_res, fast_res, fix_res;
    logic [32:0] rem_sh, rem_diff;
    logic        ge;
    logic [63:0] prod_s;
    logic [31:0] quo_s, rem_s;

    assign busy   = (state == CALC) || (state == FIX);
    assign done   = (state == DONE);
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        // 0x80000000 negates to itself, which reads correctly as an unsigned magnitude
        abs_a    = (a_signed && srcA[31]) ? -srcA : srcA;
        abs_b    = (b_signed && srcB[31]) ? -srcB : srcB;
        div_zero = funct3[2] && (srcB == 32'h0);
        div_ovf  = funct3[2] && !funct3[0] && (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = funct3[1] ? srcA : 32'hFFFF_FFFF;
        else
            special_res = funct3[1] ? 32'h0 : 32'h8000_0000;
    end

`ifdef MDU_FAST_MUL_EN
    logic [63:0] a_ext, b_ext, prod;
    always_comb begin
        a_ext    = {{32{a_signed & srcA[31]}}, srcA};
        b_ext    = {{32{b_signed & srcB[31]}}, srcB};
        prod     = a_ext * b_ext;
        fast_mul = !funct3[2];
        fast_res = (funct3 == 3'b000) ? prod[31:0] : prod[63:32];
    end
`else
    always_comb begin
        fast_mul = 1'b0;
        fast_res = 32'h0;
    end
`endif

    always_comb begin
        rem_sh   = {rem, mplier[31]};
        rem_diff = rem_sh - {1'b0, divisor};
        ge       = !rem_diff[32];
        prod_s   = neg_q ? -acc : acc;
        quo_s    = neg_q ? -mplier : mplier;
        rem_s    = neg_r ? -rem : rem;
        case (op)
            3'b000:                 fix_res = prod_s[31:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[63:32];
            3'b100, 3'b101:         fix_res = quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (start)
                    state_n = (special || fast_mul) ? DONE : CALC;
                else
                    state_n = IDLE;
            end
            CALC:    state_n = (count == 5'd31) ? FIX : CALC;
            FIX:     state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            count   <= 5'd0;
            op      <= 3'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            acc     <= 64'h0;
            mcand   <= 64'h0;
            mplier  <= 32'h0;
            rem     <= 32'h0;
            divisor <= 32'h0;
            result  <= 32'h0;
        end else begin
            state <= state_n;
            if (accept) begin
                op      <= funct3;
                count   <= 5'd0;
                neg_q   <= (a_signed & srcA[31]) ^ (b_signed & srcB[31]);
                neg_r   <= funct3[2] & a_signed & srcA[31];
                acc     <= 64'h0;
                mcand   <= {32'h0, abs_a};
                mplier  <= funct3[2] ? abs_a : abs_b;
                rem     <= 32'h0;
                divisor <= abs_b;
                if (special)
                    result <= special_res;
                else if (fast_mul)
                    result <= fast_res;
            end else if (state == CALC) begin
                count <= count + 5'd1;
                if (op[2]) begin
                    rem    <= ge ? rem_diff[31:0] : rem_sh[31:0];
                    mplier <= {mplier[30:0], ge};
                end else begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
            end else if (state == FIX) begin
                result <= fix_res;
            end
        end
    end
endmodule

// File: tb/tb_otter_mdu.sv
// tb/tb_otter_mdu.sv - Randomized self-checking bench for otter_mdu against a plain-arithmetic model
module tb_otter_mdu;
    logic        CLK;
    logic        RST;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] srcA, srcB;
    logic        busy, done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    otter_mdu dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .funct3 (funct3),
        .srcA   (srcA),
        .srcB   (srcB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib, q;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        ia = a;
        ib = b;
        p  = 64'h0;
        q  = 0;
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = ia / ib;
                return q;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = ia % ib;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
`ifdef MDU_FAST_MUL_EN
        if (!f[2])
            return 1;
`endif
        return 34;
    endfunction

    // Issues one op from the current (post-edge) point and returns once done is seen.
    // poke_at > 0 fires a stray start pulse at that cycle of the op.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, output int lat, output logic busy_seen);
        funct3 = f;
        srcA   = a;
        srcB   = b;
        start  = 1'b1;
        @(posedge CLK); #1;
        start     = 1'b0;
        lat       = 1;
        busy_seen = 1'b0;
        while (!done && lat < 100) begin
            busy_seen = busy_seen | busy;
            if (lat == poke_at) begin
                start  = 1'b1;
                funct3 = 3'b000;
                srcA   = 32'd9;
                srcB   = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            lat++;
        end
        start = 1'b0;
        if (!done) check("timeout", {31'b0, done}, 32'h1);
    endtask

    task automatic op_check(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic bs;
        run_op(f, a, b, 0, lat, bs);
        check({tag, "_res"}, result, ref_mdu(f, a, b));
        check({tag, "_lat"}, lat, ref_lat(f, a, b));
        if (ref_lat(f, a, b) == 1)
            check({tag, "_busy"}, {31'b0, bs}, 32'h0);
        @(posedge CLK); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return 32'h1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, ndone;
        logic bs;
        logic [2:0] f;
        logic [31:0] a, b;

        RST = 1'b1; start = 1'b0; funct3 = 3'b0; srcA = 32'h0; srcB = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_result", result, 32'h0);
        RST = 1'b0;
        @(posedge CLK); #1;

        op_check("mul",    3'b000, 32'h7, 32'hFFFF_FFFD);
        op_check("mulh",   3'b001, 32'h7, 32'hFFFF_FFFD);
        op_check("mulhu",  3'b011, 32'h7, 32'hFFFF_FFFD);
        op_check("mulhsu", 3'b010, 32'h7, 32'hFFFF_FFFD);
        check("mul_const", ref_mdu(3'b000, 32'h7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        op_check("div",    3'b100, 32'hFFFF_FFF9, 32'h2);
        op_check("rem",    3'b110, 32'hFFFF_FFF9, 32'h2);
        op_check("divu",   3'b101, 32'hFFFF_FFF9, 32'h2);
        op_check("remu",   3'b111, 32'hFFFF_FFF9, 32'h2);
        op_check("div0",   3'b100, 32'h1234, 32'h0);
        op_check("remu0",  3'b111, 32'h1234, 32'h0);
        op_check("dovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        op_check("rovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

        // Back-to-back with a stray start mid-CALC that must be ignored
        run_op(3'b000, 32'd3, 32'd5, 0, lat, bs);
        check("b2b_mul", result, 32'd15);
        run_op(3'b101, 32'd15, 32'd4, 5, lat, bs);
        check("b2b_divu", result, 32'd3);
        check("b2b_lat", lat, 34);
        @(posedge CLK); #1;
        check("b2b_single_done", {31'b0, done}, 32'h0);

        // Reset mid-CALC discards the op
        funct3 = 3'b101; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        check("mid_busy", {31'b0, busy}, 32'h1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("mrst_busy", {31'b0, busy}, 32'h0);
        check("mrst_done", {31'b0, done}, 32'h0);
        check("mrst_result", result, 32'h0);
        ndone = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (done) ndone++;
        end
        check("mrst_no_done", ndone, 0);

        for (int i = 0; i < 1000; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(f, a, b, 0, lat, bs);
            check("rand_res", result, ref_mdu(f, a, b));
            check("rand_lat", lat, ref_lat(f, a, b));
            if ($urandom_range(0, 1) == 0) begin
                @(posedge CLK); #1;
                check("rand_one_done", {31'b0, done}, 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
